softmax_out_pack: RTL

SOFTMAX_OUT_PACK -- requirements
Module: softmax_out_pack

---
 rtl/softmax_out_pack.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/softmax_out_pack.sv
// Packs a stream of scalar softmax results into TOUT-lane words.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   CH_in, start        - vector length and single-cycle start pulse (taken only when idle)
//   in_vld/in_rdy/in_dat      - scalar element handshake
//   out_vld/out_rdy/out_dat   - packed word handshake, lane 0 in the LSBs
//   out_last            - marks the word holding the vector's final element
//   done                - one-cycle pulse when the vector is finished
module softmax_out_pack #(
    parameter int unsigned TOUT = 8,
    parameter int unsigned DW   = 16,
    parameter int unsigned CH_W = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CH_W-1:0]      CH_in,
    input  logic                 start,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [DW-1:0]        in_dat,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [TOUT*DW-1:0]   out_dat,
    output logic                 out_last,
    output logic                 done
);

    localparam int unsigned LW = (TOUT > 1) ? $clog2(TOUT) : 1;
    localparam int unsigned WW = TOUT * DW;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [CH_W-1:0] elem_q, elem_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic [WW-1:0]   asm_dat_q, asm_dat_d;
    logic            asm_full_q, asm_full_d;
    logic            asm_last_q, asm_last_d;
    logic            in_rdy_d;
    logic            out_vld_d;
    logic [WW-1:0]   out_dat_d;
    logic            out_last_d;
    logic            done_d;

    logic            accept;
    logic            out_fire;
    logic            load;
    logic            final_elem;
    logic            complete;
    logic [CH_W-1:0] elem_inc;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            elem_q     <= '0;
            lane_q     <= '0;
            asm_dat_q  <= '0;
            asm_full_q <= 1'b0;
            asm_last_q <= 1'b0;
            in_rdy     <= 1'b0;
            out_vld    <= 1'b0;
            out_dat    <= '0;
            out_last   <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            elem_q     <= elem_d;
            lane_q     <= lane_d;
            asm_dat_q  <= asm_dat_d;
            asm_full_q <= asm_full_d;
            asm_last_q <= asm_last_d;
            in_rdy     <= in_rdy_d;
            out_vld    <= out_vld_d;
            out_dat    <= out_dat_d;
            out_last   <= out_last_d;
            done       <= done_d;
        end
    end

    // Next-state, packing and output-register logic
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        elem_d     = elem_q;
        lane_d     = lane_q;
        asm_dat_d  = asm_dat_q;
        asm_full_d = asm_full_q;
        asm_last_d = asm_last_q;
        out_vld_d  = out_vld;
        out_dat_d  = out_dat;
        out_last_d = out_last;
        done_d     = 1'b0;

        accept     = in_vld & in_rdy;
        out_fire   = out_vld & out_rdy;
        load       = asm_full_q & (~out_vld | out_rdy);
        elem_inc   = elem_q + CH_W'(1);
        final_elem = (elem_inc == ch_q);
        complete   = accept & ((lane_q == LW'(TOUT - 1)) | final_elem);

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (CH_in == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = ST_RUN;
                        ch_d       = CH_in;
                        elem_d     = '0;
                        lane_d     = '0;
                        asm_dat_d  = '0;
                        asm_full_d = 1'b0;
                        asm_last_d = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (out_fire) begin
                    out_vld_d  = 1'b0;
                    out_last_d = 1'b0;
                end
                // Moving the word out clears the assembly so unwritten lanes read zero
                if (load) begin
                    out_vld_d  = 1'b1;
                    out_dat_d  = asm_dat_q;
                    out_last_d = asm_last_q;
                    asm_dat_d  = '0;
                    asm_full_d = 1'b0;
                    asm_last_d = 1'b0;
                end
                if (accept) begin
                    for (int unsigned l = 0; l < TOUT; l++) begin
                        if (lane_q == LW'(l)) begin
                            asm_dat_d[l*DW +: DW] = in_dat;
                        end
                    end
                    elem_d = elem_inc;
                    lane_d = complete ? '0 : lane_q + LW'(1);
                    if (complete) begin
                        asm_full_d = 1'b1;
                        asm_last_d = final_elem;
                    end
                end
                if (out_fire && out_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Registered ready: drop only when a full word will meet an occupied output
        in_rdy_d = (state_d == ST_RUN) & (elem_d != ch_d) & ~(asm_full_d & out_vld_d);
    end

endmodule
